// File: rtl/repetition_transmitter.sv
// repetition_transmitter
// Takes one word over a valid/ready input and replays it REPETITION times
// on a valid/ready output, tagging each copy with its index and a last flag.
// The far end majority-votes the copies per bit.
module repetition_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int REPETITION = 3,
  localparam int INDEX_WIDTH = (REPETITION > 1) ? $clog2(REPETITION) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  input_data,
  input  logic                   input_valid,
  output logic                   input_ready,
  output logic [DATA_WIDTH-1:0]  output_data,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [INDEX_WIDTH-1:0] output_index,
  output logic                   output_last,
  output logic                   busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Index of the final copy; a freshly loaded word is already last when only one copy is sent.
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX    = INDEX_WIDTH'(REPETITION - 1);
  localparam logic                   FIRST_IS_LAST = (REPETITION == 1) ? 1'b1 : 1'b0;

  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    valid_r;
  logic [INDEX_WIDTH-1:0]  index_r;
  logic                    last_r;

  logic                    input_ready_s;
  logic                    in_xfer_s;
  logic                    out_xfer_s;
  logic [INDEX_WIDTH-1:0]  next_index_s;

  // Accept a new word when idle, or when the last copy leaves on this very edge.
  always_comb begin
    input_ready_s = 1'b0;
    case (state_r)
      IDLE: input_ready_s = 1'b1;
      SEND: begin
        if (last_r && output_ready) begin
          input_ready_s = 1'b1;
        end else begin
          input_ready_s = 1'b0;
        end
      end
      default: input_ready_s = 1'b0;
    endcase
  end

  assign in_xfer_s    = input_valid & input_ready_s;
  assign out_xfer_s   = valid_r & output_ready;
  assign next_index_s = index_r + INDEX_WIDTH'(1);

  // Word holding, copy sequencing and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      data_r  <= '0;
      valid_r <= 1'b0;
      index_r <= '0;
      last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_xfer_s) begin
            state_r <= SEND;
            data_r  <= input_data;
            valid_r <= 1'b1;
            index_r <= '0;
            last_r  <= FIRST_IS_LAST;
          end
        end
        SEND: begin
          if (out_xfer_s) begin
            if (!last_r) begin
              // Index stops at LAST_INDEX because last_r gates further increments.
              index_r <= next_index_s;
              last_r  <= (next_index_s == LAST_INDEX);
            end else if (in_xfer_s) begin
              // Back-to-back word: no idle beat between words.
              data_r  <= input_data;
              index_r <= '0;
              last_r  <= FIRST_IS_LAST;
            end else begin
              // data_r keeps the last word so the bus does not toggle while idle.
              state_r <= IDLE;
              valid_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign input_ready  = input_ready_s;
  assign output_data  = data_r;
  assign output_valid = valid_r;
  assign output_index = index_r;
  assign output_last  = last_r;
  assign busy         = valid_r;

endmodule

// File: doc/repetition_transmitter.md
# repetition_transmitter

Sending end of time-domain repetition coding. Accepts one data word through a valid/ready handshake and emits it REPETITION times on consecutive beats of a valid/ready output channel, tagging each copy with its index and a last flag. The receiving side buffers the copies and majority-votes them per bit, so this block sits between the data producer and a noisy link or storage path.

## Interface

Parameters:
- DATA_WIDTH, 8, width of the data word.
- REPETITION, 3, number of copies sent per word. Legal range is 1 or more. Odd values are expected so that majority voting is unambiguous, but this block does not enforce it.
- INDEX_WIDTH, derived, equal to max(1, $clog2(REPETITION)). Not user-overridable.

Ports:
- clock  input  1  Single clock. All state changes on the rising edge.
- reset  input  1  Asynchronous, active-high reset.
- input_data  input  DATA_WIDTH  Word to be transmitted.
- input_valid  input  1  Producer has a word on input_data.
- input_ready  output  1  Block can accept a word. Combinational from state and output_ready.
- output_data  output  DATA_WIDTH  Current copy of the word. Registered.
- output_valid  output  1  A copy is presented. Registered.
- output_ready  input  1  Downstream accepts the current copy.
- output_index  output  INDEX_WIDTH  Copy number, 0 to REPETITION-1. Registered.
- output_last  output  1  High on copy REPETITION-1. Registered.
- busy  output  1  A word is in flight. Equal to output_valid.

## Operation

- **States:**
  - IDLE: no word held.
  - SEND: a word is held and copy output_index is presented.
- **Handshakes:**
  - A transfer occurs on a beat where valid and ready are both high on the same channel.
  - Input transfer: input_valid and input_ready.
  - Output transfer: output_valid and output_ready.
- **input_ready:** equal to (state == IDLE) OR (state == SEND AND output_last AND output_ready). It never depends on input_valid.
- **IDLE:**
  - On an input transfer, latch input_data into output_data, set output_index to 0, set output_last to (REPETITION == 1), set output_valid to 1, and go to SEND.
  - Otherwise, stay in IDLE.
- **SEND, output transfer with output_last = 0:**
  - Increment output_index and keep output_data unchanged.
  - Set output_last to (output_index + 1 == REPETITION-1).
- **SEND, output transfer with output_last = 1:**
  - If there is a simultaneous input transfer, load the new word with index 0 and stay in SEND. There is no bubble.
  - Otherwise, clear output_valid and go to IDLE.
- **SEND, no output transfer:** output_data, output_index and output_last hold stable. A valid output copy never changes or drops until it is accepted.
- **output_data in IDLE:** keeps the last word sent. It is don't-care while output_valid = 0, but must not toggle.
- **REPETITION = 1:** every copy is last, and the block behaves as a one-entry pipeline register with full throughput.
- **Index arithmetic:** output_index is never incremented past REPETITION-1. No wrap occurs inside a word; the index returns to 0 only when a new word is loaded.
- **Reset:**
  - Effect: asynchronously enter IDLE and clear output_valid, output_index, output_last and output_data to 0, and busy to 0.
  - input_ready: 1 when reset is deasserted.
  - Mid-word reset: the copies not yet sent are discarded with no partial completion. The next word starts at index 0.

## Timing

- **Latency:** an input transfer at edge N causes copy 0 to become valid after edge N, so it is visible in cycle N+1.
- **Throughput:** with output_ready held high, one word is sent every REPETITION cycles. Copies 0 to REPETITION-1 appear in consecutive cycles.
- **Back-to-back:** the last copy of word A and the acceptance of word B happen on the same edge. Copy 0 of B follows the last copy of A in the very next cycle.
- **Combinational paths:** there is no path from input_valid to any output. output_ready reaches input_ready combinationally, and this is the only combinational path through the block.
- **Backpressure:** every cycle with output_ready = 0 stretches the word by exactly one cycle.

## Test plan

- **Single word:** REPETITION=3. Send 0xA5 with output_ready=1. Expect three beats of 0xA5 with index 0, 1, 2 and last=0, 0, 1. output_valid falls after the third beat. input_ready is 0 during the first two beats.
- **Backpressure:** REPETITION=3. Send 0x3C and hold output_ready=0 for 4 cycles during copy 1. Expect output_data=0x3C and index=1 to stay stable throughout. The total transfer takes 3+4 cycles, and no copy is lost or duplicated.
- **Back-to-back:** REPETITION=3, producer always valid with 0x11 then 0x22, and output_ready=1. Expect the beat sequence 0x11/0, 0x11/1, 0x11/2, 0x22/0, with no idle cycle between words and input_ready high only on the last beats.
- **Reset mid-word:** REPETITION=5. Assert reset asynchronously during copy 2 of 0xFF. Expect output_valid=0, index=0, last=0 and data=0 immediately, and input_ready=1 after deassertion. The next word 0x0F starts at index 0.
- **Degenerate case:** REPETITION=1, with a stream 0x01, 0x02, 0x03 and output_ready=1. Expect one beat per word, last=1 and index=0 on every beat, at one word per cycle.
- **Loopback:** REPETITION=3. Feed the transmitter output into the majority-vote corrector and flip one bit in one copy per word. Expect every recovered word to equal the transmitted word for 1000 random words.
